// File: rtl/picorv32_mem_bridge_pkg.sv
// Shared types and helpers for the PicoRV32 to memory-worker bridge.
package picorv32_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    ERR,
    RESP,
    GAP
  } bridge_state_t;

  localparam int unsigned WORD_ALIGN_BITS = 2;

  function automatic logic in_window(input logic [31:0]  addr,
                                     input logic [31:0]  base,
                                     input int unsigned  nbits);
    return (addr >> nbits) == (base >> nbits);
  endfunction

endpackage

// File: rtl/picorv32_mem_bridge.sv
// PicoRV32 native memory port to Simple_Worker_Mem_IF manager bridge.
module picorv32_mem_bridge
  import picorv32_bridge_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
  parameter int unsigned N_ADDR_BITS    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_mem_valid,
  input  logic        cpu_mem_instr,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  input  logic [3:0]  cpu_mem_wstrb,
  output logic        cpu_mem_ready,
  output logic [31:0] cpu_mem_rdata,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_byteEn,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] rd_addr,
  output logic        rd_valid,
  input  logic        rd_ready,
  input  logic [31:0] rd_data,
  output logic        bus_err,
  output logic [7:0]  err_count
);

  localparam int unsigned      CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT_CYCLES);

  bridge_state_t    state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             wr_valid_q, wr_valid_d;
  logic             rd_valid_q, rd_valid_d;
  logic             bus_err_q, bus_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             err_rec;

  // Fetch flag carries no behaviour for a data-only worker.
  logic unused_instr;
  assign unused_instr = cpu_mem_instr;

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      wr_valid_q <= 1'b0;
      rd_valid_q <= 1'b0;
      bus_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      wr_valid_q <= wr_valid_d;
      rd_valid_q <= rd_valid_d;
      bus_err_q  <= bus_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Next-state and output decode; handshake takes priority over timeout.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    cnt_d      = cnt_q;
    ready_d    = ready_q;
    rdata_d    = rdata_q;
    wr_valid_d = wr_valid_q;
    rd_valid_d = rd_valid_q;
    bus_err_d  = bus_err_q;
    err_cnt_d  = err_cnt_q;
    cnt_inc    = cnt_q + CNT_W'(1);
    err_rec    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cpu_mem_valid) begin
          addr_d  = cpu_mem_addr;
          wdata_d = cpu_mem_wdata;
          wstrb_d = cpu_mem_wstrb;
          if (!in_window(cpu_mem_addr, ADDR_BASE, N_ADDR_BITS) ||
              (cpu_mem_addr[WORD_ALIGN_BITS-1:0] != '0)) begin
            state_d = ERR;
          end else if (cpu_mem_wstrb != '0) begin
            state_d    = WR;
            wr_valid_d = 1'b1;
            cnt_d      = '0;
          end else begin
            state_d    = RD;
            rd_valid_d = 1'b1;
            cnt_d      = '0;
          end
        end
      end
      WR: begin
        cnt_d = cnt_inc;
        if (wr_valid_q && wr_ready) begin
          wr_valid_d = 1'b0;
          ready_d    = 1'b1;
          rdata_d    = '0;
          state_d    = RESP;
        end else if (cnt_inc == TMO) begin
          wr_valid_d = 1'b0;
          ready_d    = 1'b1;
          rdata_d    = ERR_RDATA;
          err_rec    = 1'b1;
          state_d    = RESP;
        end
      end
      RD: begin
        cnt_d = cnt_inc;
        if (rd_valid_q && rd_ready) begin
          rd_valid_d = 1'b0;
          ready_d    = 1'b1;
          rdata_d    = rd_data;
          state_d    = RESP;
        end else if (cnt_inc == TMO) begin
          rd_valid_d = 1'b0;
          ready_d    = 1'b1;
          rdata_d    = ERR_RDATA;
          err_rec    = 1'b1;
          state_d    = RESP;
        end
      end
      ERR: begin
        ready_d = 1'b1;
        rdata_d = ERR_RDATA;
        err_rec = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        ready_d = 1'b0;
        state_d = GAP;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (err_rec) begin
      bus_err_d = 1'b1;
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  assign cpu_mem_ready = ready_q;
  assign cpu_mem_rdata = rdata_q;
  assign wr_addr       = addr_q;
  assign wr_data       = wdata_q;
  assign wr_byteEn     = wstrb_q;
  assign wr_valid      = wr_valid_q;
  assign rd_addr       = addr_q;
  assign rd_valid      = rd_valid_q;
  assign bus_err       = bus_err_q;
  assign err_count     = err_cnt_q;

endmodule
